// File: rtl/switch_allocator_sep_if.sv
// Request/grant bundle between the input block, the switch allocator and the crossbar.
// The input block drives requests and credit returns; the allocator drives selects and grants.
interface switch_allocator_sep_if #(
  parameter int PORT_NUM  = 5,
  parameter int VC_NUM    = 2,
  parameter int VC_SIZE   = 1,
  parameter int PORT_SIZE = 3
);
  logic [PORT_NUM-1:0][VC_NUM-1:0]                switch_request;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   downstream_vc;
  logic [PORT_NUM-1:0]                            credit_valid;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]               credit_vc;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]               vc_sel;
  logic [PORT_NUM-1:0]                            valid_sel;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]             xb_sel;
  logic [PORT_NUM-1:0]                            xb_valid;

  modport master (
    output switch_request, out_port, downstream_vc, credit_valid, credit_vc,
    input  vc_sel, valid_sel, xb_sel, xb_valid
  );

  modport slave (
    input  switch_request, out_port, downstream_vc, credit_valid, credit_vc,
    output vc_sel, valid_sel, xb_sel, xb_valid
  );
endinterface

// File: rtl/switch_allocator_sep.sv
// Separable input-first switch allocator: per-input VC round-robin, then per-output input
// round-robin, gated by per-(output, downstream VC) credit counters.
module switch_allocator_sep #(
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int VC_SIZE     = 1,
  parameter int PORT_SIZE   = 3,
  parameter int BUFFER_SIZE = 8
) (
  input logic                   clk,
  input logic                   rst,
  switch_allocator_sep_if.slave bus
);
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  typedef logic [CW-1:0] credit_t;

  logic    [PORT_NUM-1:0][VC_SIZE-1:0]   in_ptr_q, in_ptr_d;
  logic    [PORT_NUM-1:0][PORT_SIZE-1:0] out_ptr_q, out_ptr_d;
  credit_t [PORT_NUM-1:0][VC_NUM-1:0]    credit_q, credit_d;
  logic    [PORT_NUM-1:0][VC_NUM-1:0]    credit_inc, credit_dec;

  // Stage-1 result per input
  logic [PORT_NUM-1:0]                cand_valid;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   cand_vc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] cand_port;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   cand_dvc;

  // Stage-2 result, indexed by output (grant_*_out) or by input (grant_*_in)
  logic [PORT_NUM-1:0]                grant_out;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] grant_src;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   grant_dvc;
  logic [PORT_NUM-1:0]                grant_in;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   grant_vc;

  int                 s1_v;
  logic [PORT_SIZE-1:0] s1_op;
  logic [VC_SIZE-1:0]   s1_dv;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cand_valid = '0;
    cand_vc    = '0;
    cand_port  = '0;
    cand_dvc   = '0;
    s1_v       = 0;
    s1_op      = '0;
    s1_dv      = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        s1_v  = (int'(in_ptr_q[i]) + k) % VC_NUM;
        s1_op = bus.out_port[i][s1_v];
        s1_dv = bus.downstream_vc[i][s1_v];
        if (!cand_valid[i] && bus.switch_request[i][s1_v] &&
            (int'(s1_op) < PORT_NUM) && (credit_q[s1_op][s1_dv] != '0)) begin
          cand_valid[i] = 1'b1;
          cand_vc[i]    = VC_SIZE'(s1_v);
          cand_port[i]  = s1_op;
          cand_dvc[i]   = s1_dv;
        end
      end
    end
  end

  int s2_w;

  always_comb begin
    grant_out = '0;
    grant_src = '0;
    grant_dvc = '0;
    grant_in  = '0;
    grant_vc  = '0;
    s2_w      = 0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        s2_w = (int'(out_ptr_q[o]) + k) % PORT_NUM;
        if (!grant_out[o] && cand_valid[s2_w] && (cand_port[s2_w] == PORT_SIZE'(o))) begin
          grant_out[o]   = 1'b1;
          grant_src[o]   = PORT_SIZE'(s2_w);
          grant_dvc[o]   = cand_dvc[s2_w];
          grant_in[s2_w] = 1'b1;
          grant_vc[s2_w] = cand_vc[s2_w];
        end
      end
    end
  end

  always_comb begin
    in_ptr_d   = in_ptr_q;
    out_ptr_d  = out_ptr_q;
    credit_d   = credit_q;
    credit_inc = '0;
    credit_dec = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (grant_out[o]) out_ptr_d[o] = PORT_SIZE'((int'(grant_src[o]) + 1) % PORT_NUM);
    end
    // Inputs that lose stage 2 keep their pointer so their VC order is not disturbed.
    for (int i = 0; i < PORT_NUM; i++) begin
      if (grant_in[i]) in_ptr_d[i] = VC_SIZE'((int'(grant_vc[i]) + 1) % VC_NUM);
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int d = 0; d < VC_NUM; d++) begin
        credit_inc[o][d] = bus.credit_valid[o] && (bus.credit_vc[o] == VC_SIZE'(d));
        credit_dec[o][d] = grant_out[o] && (grant_dvc[o] == VC_SIZE'(d));
        if (credit_inc[o][d] && !credit_dec[o][d] && credit_q[o][d] != credit_t'(BUFFER_SIZE))
          credit_d[o][d] = credit_q[o][d] + credit_t'(1);
        else if (credit_dec[o][d] && !credit_inc[o][d] && credit_q[o][d] != '0)
          credit_d[o][d] = credit_q[o][d] - credit_t'(1);
      end
    end
  end

  always_comb begin
    bus.valid_sel = '0;
    bus.vc_sel    = '0;
    bus.xb_valid  = '0;
    bus.xb_sel    = '0;
    if (!rst) begin
      bus.valid_sel = grant_in;
      bus.vc_sel    = grant_vc;
      bus.xb_valid  = grant_out;
      bus.xb_sel    = grant_src;
    end
  end

  // NOTE: state registers use non-blocking assignments; the credit array is reset too,
  // because a mid-operation reset must restore full credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ptr_q  <= '0;
      out_ptr_q <= '0;
      for (int o = 0; o < PORT_NUM; o++)
        for (int d = 0; d < VC_NUM; d++)
          credit_q[o][d] <= credit_t'(BUFFER_SIZE);
    end else begin
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
      credit_q  <= credit_d;
      // A credit returned to a full counter is an upstream protocol error.
      for (int o = 0; o < PORT_NUM; o++)
        for (int d = 0; d < VC_NUM; d++)
          assert (!(credit_inc[o][d] && !credit_dec[o][d] &&
                    credit_q[o][d] == credit_t'(BUFFER_SIZE)));
    end
  end
endmodule

// File: tb/tb_switch_allocator_sep.sv
// Self-checking bench for switch_allocator_sep: directed scenarios followed by random traffic,
// each cycle compared against a behavioural credit/round-robin model.
module tb_switch_allocator_sep;
  localparam int PORT_NUM    = 5;
  localparam int VC_NUM      = 2;
  localparam int VC_SIZE     = 1;
  localparam int PORT_SIZE   = 3;
  localparam int BUFFER_SIZE = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_allocator_sep_if #(.PORT_NUM(PORT_NUM), .VC_NUM(VC_NUM), .VC_SIZE(VC_SIZE),
                            .PORT_SIZE(PORT_SIZE)) bus ();

  switch_allocator_sep #(.PORT_NUM(PORT_NUM), .VC_NUM(VC_NUM), .VC_SIZE(VC_SIZE),
                         .PORT_SIZE(PORT_SIZE), .BUFFER_SIZE(BUFFER_SIZE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state
  int cred    [PORT_NUM][VC_NUM];
  int in_ptr  [PORT_NUM];
  int out_ptr [PORT_NUM];
  int cand_vc [PORT_NUM];
  int cand_op [PORT_NUM];
  int win     [PORT_NUM];

  logic [PORT_NUM-1:0]                exp_valid, exp_xbv;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   exp_vc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] exp_xbs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < PORT_NUM; o++) begin
      in_ptr[o]  = 0;
      out_ptr[o] = 0;
      for (int d = 0; d < VC_NUM; d++) cred[o][d] = BUFFER_SIZE;
    end
  endtask

  task automatic model_eval();
    int v, op, d, w;
    for (int i = 0; i < PORT_NUM; i++) begin
      cand_vc[i] = -1;
      cand_op[i] = -1;
      for (int k = 0; k < VC_NUM; k++) begin
        v  = (in_ptr[i] + k) % VC_NUM;
        op = int'(bus.out_port[i][v]);
        d  = int'(bus.downstream_vc[i][v]);
        if (cand_vc[i] < 0 && bus.switch_request[i][v] && op < PORT_NUM && cred[op][d] > 0) begin
          cand_vc[i] = v;
          cand_op[i] = op;
        end
      end
    end
    exp_valid = '0; exp_xbv = '0; exp_vc = '0; exp_xbs = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      win[o] = -1;
      for (int k = 0; k < PORT_NUM; k++) begin
        w = (out_ptr[o] + k) % PORT_NUM;
        if (win[o] < 0 && cand_vc[w] >= 0 && cand_op[w] == o) win[o] = w;
      end
      if (win[o] >= 0) begin
        exp_xbv[o]        = 1'b1;
        exp_xbs[o]        = PORT_SIZE'(win[o]);
        exp_valid[win[o]] = 1'b1;
        exp_vc[win[o]]    = VC_SIZE'(cand_vc[win[o]]);
      end
    end
  endtask

  task automatic model_commit();
    int w, v, d;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (win[o] >= 0) begin
        w = win[o];
        v = cand_vc[w];
        d = int'(bus.downstream_vc[w][v]);
        cred[o][d]--;
        out_ptr[o] = (w + 1) % PORT_NUM;
        in_ptr[w]  = (v + 1) % VC_NUM;
      end
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      d = int'(bus.credit_vc[o]);
      if (bus.credit_valid[o] && cred[o][d] < BUFFER_SIZE) cred[o][d]++;
    end
  endtask

  task automatic idle();
    bus.switch_request = '0;
    bus.out_port       = '0;
    bus.downstream_vc  = '0;
    bus.credit_valid   = '0;
    bus.credit_vc      = '0;
  endtask

  task automatic settle();
    #1;
    model_eval();
    check("valid_sel", 32'(bus.valid_sel), 32'(exp_valid));
    check("vc_sel",    32'(bus.vc_sel),    32'(exp_vc));
    check("xb_valid",  32'(bus.xb_valid),  32'(exp_xbv));
    check("xb_sel",    32'(bus.xb_sel),    32'(exp_xbs));
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst) model_commit();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_sel"}, 32'(bus.valid_sel), 32'(0));
    check({tag, "_vc_sel"},    32'(bus.vc_sel),    32'(0));
    check({tag, "_xb_valid"},  32'(bus.xb_valid),  32'(0));
    check({tag, "_xb_sel"},    32'(bus.xb_sel),    32'(0));
  endtask

  int gcount [PORT_NUM];
  int seq3   [6] = '{0, 3, 4, 0, 3, 4};

  initial begin
    // Reset: outputs forced low even with every VC requesting
    rst = 1'b1;
    idle();
    model_reset();
    bus.switch_request = '1;
    @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    idle();
    rst = 1'b0;

    // 1: single request, granted in the same cycle
    bus.switch_request[0][1] = 1'b1;
    bus.out_port[0][1]       = 3'd2;
    bus.downstream_vc[0][1]  = 1'b0;
    settle();
    check("t1_valid_sel0", 32'(bus.valid_sel[0]), 32'(1));
    check("t1_vc_sel0",    32'(bus.vc_sel[0]),    32'(1));
    check("t1_xb_valid2",  32'(bus.xb_valid[2]),  32'(1));
    check("t1_xb_sel2",    32'(bus.xb_sel[2]),    32'(0));
    advance();
    idle();

    // 2: both VCs of input 1, different outputs -> VC alternation
    bus.switch_request[1]   = 2'b11;
    bus.out_port[1][0]      = 3'd3;
    bus.out_port[1][1]      = 3'd4;
    bus.downstream_vc[1][1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      check("t2_valid_sel1", 32'(bus.valid_sel[1]), 32'(1));
      check("t2_vc_sel1",    32'(bus.vc_sel[1]),    32'(c % 2));
      advance();
    end
    idle();

    // 3: inputs 0,3,4 contend for output 1
    foreach (gcount[i]) gcount[i] = 0;
    bus.switch_request[0][0] = 1'b1; bus.out_port[0][0] = 3'd1;
    bus.switch_request[3][0] = 1'b1; bus.out_port[3][0] = 3'd1;
    bus.switch_request[4][0] = 1'b1; bus.out_port[4][0] = 3'd1;
    for (int c = 0; c < 6; c++) begin
      settle();
      check("t3_xb_valid1", 32'(bus.xb_valid[1]), 32'(1));
      check("t3_xb_sel1",   32'(bus.xb_sel[1]),   32'(seq3[c]));
      for (int i = 0; i < PORT_NUM; i++) if (bus.valid_sel[i]) gcount[i]++;
      advance();
    end
    check("t3_grants_in0", 32'(gcount[0]), 32'(2));
    check("t3_grants_in3", 32'(gcount[3]), 32'(2));
    check("t3_grants_in4", 32'(gcount[4]), 32'(2));
    idle();

    // 4: credit exhaustion on (3,1), then a single returned credit
    bus.switch_request[0][0] = 1'b1;
    bus.out_port[0][0]       = 3'd3;
    bus.downstream_vc[0][0]  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle();
      check("t4_drain_valid0", 32'(bus.valid_sel[0]), 32'(c < 8));
      advance();
    end
    bus.credit_valid[3] = 1'b1;
    bus.credit_vc[3]    = 1'b1;
    settle();
    check("t4_return_cycle_valid0", 32'(bus.valid_sel[0]), 32'(0));
    advance();
    bus.credit_valid[3] = 1'b0;
    settle();
    check("t4_after_return_valid0", 32'(bus.valid_sel[0]), 32'(1));
    advance();
    settle();
    check("t4_empty_again_valid0", 32'(bus.valid_sel[0]), 32'(0));
    advance();

    // 5: refill (3,1) to 4, then grant and return together leaves it at 4
    bus.switch_request[0][0] = 1'b0;
    bus.credit_valid[3]      = 1'b1;
    bus.credit_vc[3]         = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      advance();
    end
    bus.switch_request[0][0] = 1'b1;
    settle();
    check("t5_simul_valid0", 32'(bus.valid_sel[0]), 32'(1));
    advance();
    bus.credit_valid[3] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      settle();
      check("t5_four_left_valid0", 32'(bus.valid_sel[0]), 32'(c < 4));
      advance();
    end
    idle();

    // 6: drain (2,0) to 3, reset mid-traffic, full credits afterwards
    bus.switch_request[0][1] = 1'b1;
    bus.out_port[0][1]       = 3'd2;
    bus.switch_request[2][0] = 1'b1;
    bus.out_port[2][0]       = 3'd4;
    for (int c = 0; c < 4; c++) begin
      settle();
      advance();
    end
    #2 rst = 1'b1;
    model_reset();
    #1 check_all_zero("t6_in_reset");
    @(negedge clk);
    rst = 1'b0;
    idle();
    bus.switch_request[0] = 2'b11; bus.out_port[0][0] = 3'd2; bus.out_port[0][1] = 3'd2;
    bus.switch_request[2][1] = 1'b1; bus.out_port[2][1] = 3'd2;
    bus.switch_request[3][0] = 1'b1; bus.out_port[3][0] = 3'd2;
    settle();
    check("t6_first_valid_sel", 32'(bus.valid_sel), 32'(5'b00001));
    check("t6_first_vc_sel0",   32'(bus.vc_sel[0]), 32'(0));
    check("t6_first_xb_sel2",   32'(bus.xb_sel[2]), 32'(0));
    advance();
    for (int c = 1; c < 10; c++) begin
      settle();
      check("t6_full_credit_xb_valid2", 32'(bus.xb_valid[2]), 32'(c < 8));
      advance();
    end
    idle();
    bus.credit_valid = 5'b00100;
    bus.credit_vc    = '0;
    for (int c = 0; c < 8; c++) begin
      settle();
      advance();
    end

    // Random traffic against the model; credits only returned where the model has room
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          bus.switch_request[i][v] = ($urandom_range(0, 9) < 6);
          bus.out_port[i][v]       = PORT_SIZE'($urandom_range(0, PORT_NUM - 1));
          bus.downstream_vc[i][v]  = VC_SIZE'($urandom_range(0, VC_NUM - 1));
        end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        int d;
        d = int'($urandom_range(0, VC_NUM - 1));
        bus.credit_vc[o]    = VC_SIZE'(d);
        bus.credit_valid[o] = (cred[o][d] < BUFFER_SIZE) && ($urandom_range(0, 2) != 0);
      end
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
